// File: rtl/ex_uop_issue.sv
`default_nettype none
// ============================================================================
// Module   : ex_uop_issue
// Brief    : Bundle FIFO between the uop feed and the execute datapath; issues
//            one uop per cycle with first/last instruction-boundary marks.
// Revision : 1.0
// ============================================================================
module ex_uop_issue #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        a_rst,
   output logic        feed_req,
   input  logic        feed_ack,
   input  logic [19:0] uop_0,
   input  logic [19:0] uop_1,
   input  logic [19:0] uop_2,
   input  logic [1:0]  uop_count,
   input  logic [15:0] k,
   input  logic        flush,
   input  logic        dp_rdy,
   output logic        dp_valid,
   output logic [19:0] dp_uop,
   output logic [15:0] dp_k,
   output logic        dp_first,
   output logic        dp_last,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [19:0]   r_uop0 [DEPTH];
   logic [19:0]   r_uop1 [DEPTH];
   logic [19:0]   r_uop2 [DEPTH];
   logic [1:0]    r_cnt  [DEPTH];
   logic [15:0]   r_k    [DEPTH];

   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_occ;
   logic [1:0]    r_idx;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_fire;
   logic          w_pop;
   logic          w_at_last;
   logic [1:0]    w_head_cnt;

   assign w_full     = (r_occ == CW'(DEPTH));
   assign w_empty    = (r_occ == '0);
   assign w_head_cnt = r_cnt[r_rd];
   assign w_at_last  = (r_idx == (w_head_cnt - 2'd1));

   assign feed_req = ~w_full & ~flush & ~a_rst;
   // A zero-uop bundle completes the handshake but occupies no entry.
   assign w_push   = feed_req & feed_ack & (uop_count != 2'd0);

   assign dp_valid = ~w_empty & ~flush & ~a_rst;
   assign dp_k     = r_k[r_rd];
   assign dp_first = dp_valid & (r_idx == 2'd0);
   assign dp_last  = dp_valid & w_at_last;
   assign busy     = ~w_empty & ~a_rst;

   always_comb begin
      dp_uop = r_uop2[r_rd];
      case (r_idx)
         2'd0:    dp_uop = r_uop0[r_rd];
         2'd1:    dp_uop = r_uop1[r_rd];
         default: dp_uop = r_uop2[r_rd];
      endcase
   end

   assign w_fire = dp_valid & dp_rdy;
   assign w_pop  = w_fire & w_at_last;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_uop0[r_wr] <= uop_0;
         r_uop1[r_wr] <= uop_1;
         r_uop2[r_wr] <= uop_2;
         r_cnt[r_wr]  <= uop_count;
         r_k[r_wr]    <= k;
      end
   end

   // Flush shares the reset path so it wins over any push or pop this cycle.
   always_ff @(posedge clk) begin
      if (a_rst || flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_occ <= '0;
         r_idx <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd  <= r_rd + 1'b1;
            r_idx <= 2'd0;
         end else if (w_fire) begin
            r_idx <= r_idx + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_uop_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_uop_issue
// Brief    : Directed and random stimulus for ex_uop_issue against a uop-stream
//            reference model.
// Revision : 1.0
// ============================================================================
module tb_ex_uop_issue;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        a_rst = 1'b0;
   logic        feed_req;
   logic        feed_ack = 1'b0;
   logic [19:0] uop_0 = '0;
   logic [19:0] uop_1 = '0;
   logic [19:0] uop_2 = '0;
   logic [1:0]  uop_count = '0;
   logic [15:0] k = '0;
   logic        flush = 1'b0;
   logic        dp_rdy = 1'b0;
   logic        dp_valid;
   logic [19:0] dp_uop;
   logic [15:0] dp_k;
   logic        dp_first;
   logic        dp_last;
   logic        busy;

   ex_uop_issue #(.DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .a_rst     (a_rst),
      .feed_req  (feed_req),
      .feed_ack  (feed_ack),
      .uop_0     (uop_0),
      .uop_1     (uop_1),
      .uop_2     (uop_2),
      .uop_count (uop_count),
      .k         (k),
      .flush     (flush),
      .dp_rdy    (dp_rdy),
      .dp_valid  (dp_valid),
      .dp_uop    (dp_uop),
      .dp_k      (dp_k),
      .dp_first  (dp_first),
      .dp_last   (dp_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] u;
      logic [15:0] kk;
      logic        f;
      logic        l;
   } item_t;

   // Reference: flat stream of uops still to issue, and uop counts of queued bundles.
   item_t iq[$];
   int    bq[$];
   int    checks = 0;
   int    errors = 0;
   bit    accepted;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic  exp_req;
      logic  exp_val;
      item_t it;
      @(negedge clk);
      exp_req = !a_rst && !flush && (bq.size() < DEPTH);
      exp_val = !a_rst && !flush && (iq.size() > 0);
      chk("feed_req", {31'd0, feed_req}, {31'd0, exp_req});
      chk("dp_valid", {31'd0, dp_valid}, {31'd0, exp_val});
      chk("busy", {31'd0, busy}, {31'd0, (!a_rst && bq.size() > 0)});
      if (a_rst) begin
         chk("dp_first_rst", {31'd0, dp_first}, 32'd0);
         chk("dp_last_rst", {31'd0, dp_last}, 32'd0);
      end
      if (exp_val) begin
         chk("dp_uop", {12'd0, dp_uop}, {12'd0, iq[0].u});
         chk("dp_k", {16'd0, dp_k}, {16'd0, iq[0].kk});
         chk("dp_first", {31'd0, dp_first}, {31'd0, iq[0].f});
         chk("dp_last", {31'd0, dp_last}, {31'd0, iq[0].l});
      end
      accepted = 1'b0;
      if (a_rst || flush) begin
         iq.delete();
         bq.delete();
      end else begin
         if (exp_val && dp_rdy) begin
            if (iq[0].l) void'(bq.pop_front());
            void'(iq.pop_front());
         end
         if (exp_req && feed_ack) begin
            accepted = 1'b1;
            if (uop_count != 2'd0) begin
               bq.push_back(int'(uop_count));
               for (int j = 0; j < int'(uop_count); j++) begin
                  it.u  = (j == 0) ? uop_0 : (j == 1) ? uop_1 : uop_2;
                  it.kk = k;
                  it.f  = (j == 0);
                  it.l  = (j == int'(uop_count) - 1);
                  iq.push_back(it);
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Present a bundle until it is taken, with a bounded wait.
   task automatic offer(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c,
                        input logic [1:0] n, input logic [15:0] kk);
      uop_0 = a; uop_1 = b; uop_2 = c; uop_count = n; k = kk;
      feed_ack = 1'b1;
      for (int t = 0; t < 20; t++) begin
         step();
         if (accepted) break;
      end
      chk("offer_accepted", {31'd0, accepted}, 32'd1);
      feed_ack = 1'b0;
   endtask

   initial begin
      #1;
      // Reset with a bundle presented: nothing may be taken.
      a_rst = 1'b1; feed_ack = 1'b1; uop_0 = 20'hAAAAA; uop_count = 2'd1;
      step(); step();
      a_rst = 1'b0; feed_ack = 1'b0;
      step();

      // Three-uop bundle issued back to back.
      dp_rdy = 1'b1;
      offer(20'h11111, 20'h22222, 20'h33333, 2'd3, 16'hBEEF);
      repeat (4) step();

      // Stall, fill the FIFO, then drain.
      dp_rdy = 1'b0;
      offer(20'h11111, 20'h22222, 20'h33333, 2'd3, 16'hBEEF);
      offer(20'h44444, 20'h0, 20'h0, 2'd1, 16'h1234);
      uop_0 = 20'h55555; uop_count = 2'd1; k = 16'h5678; feed_ack = 1'b1;
      step(); step();
      dp_rdy = 1'b1;
      offer(20'h55555, 20'h0, 20'h0, 2'd1, 16'h5678);
      repeat (6) step();

      // Empty bundle.
      offer(20'h12345, 20'h0, 20'h0, 2'd0, 16'h0001);
      repeat (2) step();

      // Flush in the middle of a bundle with a bundle presented.
      offer(20'h0A0A0, 20'h0B0B0, 20'h0C0C0, 2'd3, 16'hCAFE);
      step();
      flush = 1'b1; feed_ack = 1'b1; uop_0 = 20'h0DDDD; uop_count = 2'd1;
      step();
      flush = 1'b0; feed_ack = 1'b0;
      repeat (2) step();

      // Eight back-to-back single-uop bundles.
      for (int i = 1; i <= 8; i++) offer(20'(i), 20'h0, 20'h0, 2'd1, 16'(16'h100 + i));
      repeat (3) step();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         feed_ack  = ($urandom_range(0, 3) != 0);
         uop_0     = 20'($urandom);
         uop_1     = 20'($urandom);
         uop_2     = 20'($urandom);
         uop_count = 2'($urandom_range(0, 3));
         k         = 16'($urandom);
         dp_rdy    = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         a_rst     = ($urandom_range(0, 99) == 0);
         step();
      end
      a_rst = 1'b0; flush = 1'b0; feed_ack = 1'b0; dp_rdy = 1'b1;
      repeat (10) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
